vending_machine_mc: RTL and testbench

- Parametrised next-generation vending core: N products, configurable denomination set, per-product stock counters and a tracked change-coin inventory.
- Accumulates inserted coins and notes as credit. Checks that exact change is feasible before vending.
- Dispenses the product, then returns change one coin per handshake. Also supports a cancel/refund path.
- Instantiated directly under dut_top; coin and product mechanisms connect through valid/ready handshakes.

---
 rtl/vending_machine_mc.sv | 210 +++++++++++++++++++++
 tb/tb_vending_machine_mc.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_mc.sv
// Vending core: credit accumulation, change feasibility search,
// product dispense and one-coin-per-handshake change return.
module vending_machine_mc #(
  parameter int NUM_PRODUCTS = 8,
  parameter int NUM_DENOM = 15,
  parameter int VALUE_W = 16,
  parameter int CREDIT_W = 16,
  parameter logic [NUM_PRODUCTS*VALUE_W-1:0] PRICES = {
    16'd45, 16'd1000, 16'd90, 16'd500,
    16'd125, 16'd300, 16'd275, 16'd150},
  parameter logic [NUM_DENOM*VALUE_W-1:0] DENOM_VALUES = {
    16'd1, 16'd2, 16'd5, 16'd10, 16'd25,
    16'd50, 16'd100, 16'd200, 16'd500,
    16'd1000, 16'd2000, 16'd5000,
    16'd10000, 16'd20000, 16'd50000},
  parameter int COUNT_W = 8,
  parameter int DENOM_INIT_COUNT = 8,
  parameter int STOCK_W = 8,
  parameter int STOCK_INIT = 10,
  localparam int MW = $clog2(NUM_DENOM),
  localparam int PW = $clog2(NUM_PRODUCTS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [MW-1:0] i_money,
  input  logic          i_money_valid,
  input  logic [PW-1:0] i_product_code,
  input  logic          i_buy,
  input  logic          i_cancel,
  output logic [PW-1:0] o_product_code,
  output logic          o_product_valid,
  input  logic          i_product_ready,
  output logic [MW-1:0] o_change_denomination_code,
  output logic          o_change_valid,
  input  logic          i_change_ready,
  output logic          o_no_change,
  output logic          o_sold_out,
  output logic [CREDIT_W-1:0] o_credit,
  output logic          o_busy
);

  localparam int JW = $clog2(NUM_DENOM + 1);
  localparam int SW =
    (CREDIT_W > VALUE_W ? CREDIT_W : VALUE_W) + 1;

  typedef enum logic [1:0] {
    IDLE, CHECK, VEND, CHANGE
  } state_t;

  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic refund_q, refund_d;
  logic [PW-1:0] code_q, code_d;
  logic [JW-1:0] j_q, j_d;
  logic [COUNT_W-1:0] cnt_q [NUM_DENOM];
  logic [COUNT_W-1:0] cnt_d [NUM_DENOM];
  logic [COUNT_W-1:0] take_q [NUM_DENOM];
  logic [COUNT_W-1:0] take_d [NUM_DENOM];
  logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0] stock_d [NUM_PRODUCTS];
  logic sold_q, sold_d;
  logic noch_q, noch_d;

  logic [SW-1:0] msum, mval, pval, dv;
  logic money_ok, code_bad, any_take;
  logic [MW-1:0] low;

  function automatic logic [VALUE_W-1:0] dval(input int i);
    return DENOM_VALUES[i*VALUE_W +: VALUE_W];
  endfunction

  function automatic logic [VALUE_W-1:0] pprice(input int i);
    return PRICES[i*VALUE_W +: VALUE_W];
  endfunction

  // Lowest denomination index still owed as change
  always_comb begin
    any_take = 1'b0;
    low = '0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (take_q[i] != '0) begin
        any_take = 1'b1;
        low = MW'(i);
      end
    end
  end

  // Coin acceptance, purchase/refund launch, search and handshakes
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    rem_d = rem_q;
    refund_d = refund_q;
    code_d = code_q;
    j_d = j_q;
    cnt_d = cnt_q;
    take_d = take_q;
    stock_d = stock_q;
    sold_d = 1'b0;
    noch_d = 1'b0;
    mval = SW'(dval(int'(i_money)));
    msum = SW'(credit_q) + mval;
    money_ok = (int'(i_money) < NUM_DENOM) &&
      (msum <= SW'({CREDIT_W{1'b1}}));
    code_bad = int'(i_product_code) >= NUM_PRODUCTS;
    pval = SW'(pprice(int'(i_product_code)));
    dv = SW'(dval(int'(j_q)));
    unique case (state_q)
      IDLE: begin
        if (i_buy) begin
          if (code_bad || stock_q[i_product_code] == '0) begin
            sold_d = 1'b1;
          end else if (SW'(credit_q) >= pval) begin
            code_d = i_product_code;
            rem_d = CREDIT_W'(SW'(credit_q) - pval);
            refund_d = 1'b0;
            j_d = '0;
            state_d = CHECK;
          end
        end else if (i_cancel) begin
          if (credit_q != '0) begin
            rem_d = credit_q;
            refund_d = 1'b1;
            j_d = '0;
            state_d = CHECK;
          end
        end else if (i_money_valid && money_ok) begin
          credit_d = CREDIT_W'(msum);
          if (cnt_q[i_money] != {COUNT_W{1'b1}})
            cnt_d[i_money] = cnt_q[i_money] + COUNT_W'(1);
        end
      end
      CHECK: begin
        if (rem_q == '0) begin
          state_d = refund_q ? CHANGE : VEND;
          if (refund_q) credit_d = '0;
        end else if (j_q == JW'(NUM_DENOM)) begin
          for (int i = 0; i < NUM_DENOM; i++) take_d[i] = '0;
          noch_d = 1'b1;
          state_d = IDLE;
        end else if (SW'(rem_q) >= dv &&
                     cnt_q[j_q] > take_q[j_q]) begin
          rem_d = CREDIT_W'(SW'(rem_q) - dv);
          take_d[j_q] = take_q[j_q] + COUNT_W'(1);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      VEND: begin
        if (i_product_ready) begin
          stock_d[code_q] = stock_q[code_q] - STOCK_W'(1);
          credit_d = '0;
          state_d = CHANGE;
        end
      end
      CHANGE: begin
        if (!any_take) begin
          state_d = IDLE;
        end else if (i_change_ready) begin
          take_d[low] = take_q[low] - COUNT_W'(1);
          cnt_d[low] = cnt_q[low] - COUNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, credit, inventories and pulse registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      credit_q <= '0;
      rem_q <= '0;
      refund_q <= 1'b0;
      code_q <= '0;
      j_q <= '0;
      sold_q <= 1'b0;
      noch_q <= 1'b0;
      for (int i = 0; i < NUM_DENOM; i++) begin
        cnt_q[i] <= COUNT_W'(DENOM_INIT_COUNT);
        take_q[i] <= '0;
      end
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      rem_q <= rem_d;
      refund_q <= refund_d;
      code_q <= code_d;
      j_q <= j_d;
      sold_q <= sold_d;
      noch_q <= noch_d;
      cnt_q <= cnt_d;
      take_q <= take_d;
      stock_q <= stock_d;
    end
  end

  assign o_product_valid = state_q == VEND;
  assign o_product_code = o_product_valid ? code_q : '0;
  assign o_change_valid = (state_q == CHANGE) && any_take;
  assign o_change_denomination_code = o_change_valid ? low : '0;
  assign o_no_change = noch_q;
  assign o_sold_out = sold_q;
  assign o_credit = credit_q;
  assign o_busy = state_q != IDLE;

endmodule

// File: tb/tb_vending_machine_mc.sv
// Bench for vending_machine_mc: three parameter variants share one
// stimulus stream and are checked each cycle against a purchase model.
module tb_vending_machine_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] money = '0;
  logic mv = 1'b0;
  logic [2:0] pcode = '0;
  logic buy = 1'b0;
  logic cancel = 1'b0;
  logic pready = 1'b1;
  logic cready = 1'b1;

  logic [2:0] o_pc [3];
  logic o_pv [3];
  logic [3:0] o_cc [3];
  logic o_cv [3];
  logic o_nc [3];
  logic o_so [3];
  logic [15:0] o_cr [3];
  logic o_busy [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vending_machine_mc u0 (
    .i_clk(clk), .i_rst(rst), .i_money(money),
    .i_money_valid(mv), .i_product_code(pcode),
    .i_buy(buy), .i_cancel(cancel),
    .o_product_code(o_pc[0]), .o_product_valid(o_pv[0]),
    .i_product_ready(pready),
    .o_change_denomination_code(o_cc[0]),
    .o_change_valid(o_cv[0]), .i_change_ready(cready),
    .o_no_change(o_nc[0]), .o_sold_out(o_so[0]),
    .o_credit(o_cr[0]), .o_busy(o_busy[0]));

  vending_machine_mc #(.STOCK_INIT(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_money(money),
    .i_money_valid(mv), .i_product_code(pcode),
    .i_buy(buy), .i_cancel(cancel),
    .o_product_code(o_pc[1]), .o_product_valid(o_pv[1]),
    .i_product_ready(pready),
    .o_change_denomination_code(o_cc[1]),
    .o_change_valid(o_cv[1]), .i_change_ready(cready),
    .o_no_change(o_nc[1]), .o_sold_out(o_so[1]),
    .o_credit(o_cr[1]), .o_busy(o_busy[1]));

  vending_machine_mc #(.DENOM_INIT_COUNT(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_money(money),
    .i_money_valid(mv), .i_product_code(pcode),
    .i_buy(buy), .i_cancel(cancel),
    .o_product_code(o_pc[2]), .o_product_valid(o_pv[2]),
    .i_product_ready(pready),
    .o_change_denomination_code(o_cc[2]),
    .o_change_valid(o_cv[2]), .i_change_ready(cready),
    .o_no_change(o_nc[2]), .o_sold_out(o_so[2]),
    .o_credit(o_cr[2]), .o_busy(o_busy[2]));

  int price [8] = '{150, 275, 300, 125, 500, 90, 1000, 45};
  int dv [15] = '{50000, 20000, 10000, 5000, 2000, 1000,
                  500, 200, 100, 50, 25, 10, 5, 2, 1};
  int stock_init [3] = '{10, 1, 10};
  int cnt_init [3] = '{8, 8, 0};

  // model: phase 0 idle, 1 searching, 2 dispensing, 3 paying out
  int m_ph [3];
  int m_cr [3];
  int m_stock [3][8];
  int m_cnt [3][15];
  int m_take [3][15];
  int m_wait [3];
  bit m_ok [3];
  bit m_refund [3];
  int m_code [3];
  bit m_so [3];
  bit m_nc [3];

  int pseq [3][16];
  int pn [3];
  int cseq [3][16];
  int cn [3];
  int so_n [3];
  int nc_n [3];

  task automatic chk(string nm, int k, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] got %0d expected %0d",
               nm, k, act, exp);
    end
  endtask

  function automatic int lowest(int k);
    for (int j = 0; j < 15; j++)
      if (m_take[k][j] > 0) return j;
    return -1;
  endfunction

  // greedy payout with limited coins; search time follows from
  // coins taken plus index steps walked
  task automatic plan(int k, int rem, bit refund);
    int n;
    int tot;
    int last;
    tot = 0;
    last = 0;
    for (int j = 0; j < 15; j++) begin
      n = rem / dv[j];
      if (n > m_cnt[k][j]) n = m_cnt[k][j];
      m_take[k][j] = n;
      rem -= n * dv[j];
      tot += n;
      if (n > 0) last = j;
    end
    m_ok[k] = rem == 0;
    if (!m_ok[k]) m_wait[k] = tot + 15 + 1;
    else if (tot == 0) m_wait[k] = 1;
    else m_wait[k] = tot + last + 1;
    m_refund[k] = refund;
    m_ph[k] = 1;
  endtask

  task automatic model_step(int k);
    int lo;
    if (rst) begin
      m_ph[k] = 0;
      m_cr[k] = 0;
      m_so[k] = 0;
      m_nc[k] = 0;
      m_code[k] = 0;
      for (int p = 0; p < 8; p++) m_stock[k][p] = stock_init[k];
      for (int j = 0; j < 15; j++) begin
        m_cnt[k][j] = cnt_init[k];
        m_take[k][j] = 0;
      end
      return;
    end
    m_so[k] = 0;
    m_nc[k] = 0;
    case (m_ph[k])
      0: begin
        if (buy) begin
          if (m_stock[k][pcode] == 0) m_so[k] = 1;
          else if (m_cr[k] >= price[pcode]) begin
            m_code[k] = pcode;
            plan(k, m_cr[k] - price[pcode], 0);
          end
        end else if (cancel) begin
          if (m_cr[k] != 0) plan(k, m_cr[k], 1);
        end else if (mv && money < 15) begin
          if (m_cr[k] + dv[money] <= 65535) begin
            m_cr[k] += dv[money];
            if (m_cnt[k][money] < 255) m_cnt[k][money]++;
          end
        end
      end
      1: begin
        m_wait[k]--;
        if (m_wait[k] == 0) begin
          if (m_ok[k]) begin
            m_ph[k] = m_refund[k] ? 3 : 2;
            if (m_refund[k]) m_cr[k] = 0;
          end else begin
            m_ph[k] = 0;
            m_nc[k] = 1;
            for (int j = 0; j < 15; j++) m_take[k][j] = 0;
          end
        end
      end
      2: begin
        if (pready) begin
          m_stock[k][m_code[k]]--;
          m_cr[k] = 0;
          m_ph[k] = 3;
        end
      end
      default: begin
        lo = lowest(k);
        if (lo < 0) m_ph[k] = 0;
        else if (cready) begin
          m_take[k][lo]--;
          m_cnt[k][lo]--;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
  end

  // per-cycle compare and handshake recording
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int lo;
        bit ev;
        lo = lowest(k);
        ev = (m_ph[k] == 3) && (lo >= 0);
        chk("busy", k, 32'(o_busy[k]), 32'(m_ph[k] != 0));
        chk("credit", k, 32'(o_cr[k]), 32'(m_cr[k]));
        chk("sold_out", k, 32'(o_so[k]), 32'(m_so[k]));
        chk("no_change", k, 32'(o_nc[k]), 32'(m_nc[k]));
        chk("prod_valid", k, 32'(o_pv[k]), 32'(m_ph[k] == 2));
        if (m_ph[k] == 2)
          chk("prod_code", k, 32'(o_pc[k]), 32'(m_code[k]));
        chk("chg_valid", k, 32'(o_cv[k]), 32'(ev));
        if (ev)
          chk("chg_code", k, 32'(o_cc[k]), 32'(lo));
        if (!rst) begin
          if (o_pv[k] && pready && pn[k] < 16) begin
            pseq[k][pn[k]] = int'(o_pc[k]);
            pn[k]++;
          end
          if (o_cv[k] && cready && cn[k] < 16) begin
            cseq[k][cn[k]] = int'(o_cc[k]);
            cn[k]++;
          end
          if (o_so[k]) so_n[k]++;
          if (o_nc[k]) nc_n[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pn[k] = 0;
      cn[k] = 0;
      so_n[k] = 0;
      nc_n[k] = 0;
    end
  endtask

  task automatic coin(int idx);
    money = 4'(idx);
    mv = 1'b1;
    tick();
    mv = 1'b0;
  endtask

  task automatic do_buy(int code);
    pcode = 3'(code);
    buy = 1'b1;
    tick();
    buy = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_busy[0] || o_busy[1] || o_busy[2]) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL idle_timeout got busy expected idle");
    end
    tick();
  endtask

  task automatic wait_chg0();
    int n;
    n = 0;
    while (!o_cv[0] && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL chg_timeout got no change coin expected one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk_en = 1'b1;
    do_reset();

    // 200 + 50, buy product 0 (150): one 100 coin back
    coin(7);
    coin(9);
    chk("s1_credit", 0, 32'(o_cr[0]), 250);
    do_buy(0);
    wait_idle();
    chk("s1_credit_after", 0, 32'(o_cr[0]), 0);
    chk("s1_stock0", 0, m_stock[0][0], 9);
    chk("s1_count8", 0, m_cnt[0][8], 7);
    chk("s1_prod_n", 0, pn[0], 1);
    chk("s1_prod_code", 0, pseq[0][0], 0);
    chk("s1_chg_n", 0, cn[0], 1);
    chk("s1_chg_code", 0, cseq[0][0], 8);
    chk("s1_nochg", 2, nc_n[2], 1);
    chk("s1_keep_credit", 2, 32'(o_cr[2]), 250);

    // short credit, invalid index and overflow are ignored
    do_reset();
    coin(8);
    do_buy(1);
    chk("s2_busy", 0, 32'(o_busy[0]), 0);
    chk("s2_credit", 0, 32'(o_cr[0]), 100);
    coin(15);
    chk("s2_bad_idx", 0, 32'(o_cr[0]), 100);
    coin(0);
    chk("s2_big", 0, 32'(o_cr[0]), 50100);
    coin(1);
    chk("s2_overflow", 0, 32'(o_cr[0]), 50100);
    do_cancel();
    wait_idle();
    chk("s2_refund_n", 0, cn[0], 2);
    chk("s2_refund_0", 0, cseq[0][0], 0);
    chk("s2_refund_1", 0, cseq[0][1], 8);
    chk("s2_credit_after", 0, 32'(o_cr[0]), 0);

    // single unit of stock: second purchase is sold out
    do_reset();
    coin(6);
    do_buy(5);
    wait_idle();
    coin(6);
    do_buy(5);
    wait_idle();
    chk("s3_sold_n", 1, so_n[1], 1);
    chk("s3_credit", 1, 32'(o_cr[1]), 500);
    chk("s3_u0_credit", 0, 32'(o_cr[0]), 0);
    chk("s3_stock5", 1, m_stock[1][5], 0);

    // empty hopper: no change, then refund the note itself
    do_reset();
    coin(6);
    do_buy(0);
    wait_idle();
    chk("s4_nochg", 2, nc_n[2], 1);
    chk("s4_noprod", 2, pn[2], 0);
    chk("s4_credit", 2, 32'(o_cr[2]), 500);
    pready = 1'b0;
    do_cancel();
    tick();
    tick();
    pready = 1'b1;
    wait_idle();
    chk("s4_refund_n", 2, cn[2], 1);
    chk("s4_refund_code", 2, cseq[2][0], 6);
    chk("s4_credit_after", 2, 32'(o_cr[2]), 0);
    chk("s4_u0_chg_n", 0, cn[0], 3);

    // stalled hopper keeps the change code stable
    do_reset();
    coin(6);
    coin(9);
    do_buy(6);
    chk("s5_busy", 0, 32'(o_busy[0]), 0);
    chk("s5_credit", 0, 32'(o_cr[0]), 550);
    cready = 1'b0;
    do_buy(2);
    wait_chg0();
    repeat (5) begin
      chk("s5_stall_code", 0, 32'(o_cc[0]), 7);
      chk("s5_stall_valid", 0, 32'(o_cv[0]), 1);
      tick();
    end
    cready = 1'b1;
    wait_idle();
    chk("s5_chg_n", 0, cn[0], 2);
    chk("s5_chg_0", 0, cseq[0][0], 7);
    chk("s5_chg_1", 0, cseq[0][1], 9);

    // reset in the middle of payout
    do_reset();
    coin(6);
    cready = 1'b0;
    do_buy(7);
    wait_chg0();
    do_reset();
    chk("s6_cv", 0, 32'(o_cv[0]), 0);
    chk("s6_pv", 0, 32'(o_pv[0]), 0);
    chk("s6_busy", 0, 32'(o_busy[0]), 0);
    chk("s6_credit", 0, 32'(o_cr[0]), 0);
    chk("s6_count7", 0, m_cnt[0][7], 8);
    cready = 1'b1;
    coin(6);
    do_buy(7);
    wait_idle();
    chk("s6_chg_n", 0, cn[0], 4);
    chk("s6_chg_0", 0, cseq[0][0], 7);
    chk("s6_chg_1", 0, cseq[0][1], 7);
    chk("s6_chg_2", 0, cseq[0][2], 9);
    chk("s6_chg_3", 0, cseq[0][3], 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
